// File: rtl/stage_if.sv
`default_nettype none
// stage_if -- RV32I instruction fetch: fetch PC, req/ack fetch FSM, prefetch FIFO, IF/ID register. Rev 1.0
// Define IF_PREFETCH_EN for a 2-entry prefetch FIFO; otherwise the FIFO holds a single word.
module stage_if #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        inst_valid
);

    localparam logic [31:0] C_NOP = 32'h0000_0013;
`ifdef IF_PREFETCH_EN
    localparam logic [1:0]  C_DEPTH = 2'd2;
`else
    localparam logic [1:0]  C_DEPTH = 2'd1;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] fetch_pc_q;
    logic        mem_req_q;
    logic [31:0] mem_addr_q;

    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        valid_q, valid_d;

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] head_pc_q, head_pc_d;
    logic [31:0] head_inst_q, head_inst_d;
`ifdef IF_PREFETCH_EN
    logic [31:0] tail_pc_q, tail_pc_d;
    logic [31:0] tail_inst_q, tail_inst_d;
`endif

    logic [31:0] redirect_pc;
    logic        unused_tgt_lsbs;
    logic        ack_in_wait;
    logic        take;
    logic        fifo_empty;
    logic        pop;
    logic        push;
    logic        bypass;

    assign redirect_pc     = {br_target[31:2], 2'b00};
    assign unused_tgt_lsbs = &{1'b0, br_target[1:0]};

    // Only an ack to a live (WAIT) request carries usable data; DROP acks are discarded.
    assign ack_in_wait = mem_ack && (state_q == S_WAIT);
    assign take        = ack_in_wait && !br_taken;
    assign fifo_empty  = (cnt_q == 2'd0);
    assign pop         = !br_taken && !stall && !fifo_empty;
    assign push        = take && (stall || !fifo_empty);
    assign bypass      = take && !stall && fifo_empty;

    always_comb begin
        head_pc_d   = head_pc_q;
        head_inst_d = head_inst_q;
        cnt_d       = cnt_q;
`ifdef IF_PREFETCH_EN
        tail_pc_d   = tail_pc_q;
        tail_inst_d = tail_inst_q;
`endif
        if (br_taken) begin
            cnt_d = 2'd0;
        end else if (pop && push) begin
`ifdef IF_PREFETCH_EN
            if (cnt_q == 2'd2) begin
                head_pc_d   = tail_pc_q;
                head_inst_d = tail_inst_q;
                tail_pc_d   = mem_addr_q;
                tail_inst_d = mem_rdata;
            end else begin
                head_pc_d   = mem_addr_q;
                head_inst_d = mem_rdata;
            end
`else
            head_pc_d   = mem_addr_q;
            head_inst_d = mem_rdata;
`endif
        end else if (pop) begin
            cnt_d = cnt_q - 2'd1;
`ifdef IF_PREFETCH_EN
            head_pc_d   = tail_pc_q;
            head_inst_d = tail_inst_q;
`endif
        end else if (push) begin
            cnt_d = cnt_q + 2'd1;
`ifdef IF_PREFETCH_EN
            if (fifo_empty) begin
                head_pc_d   = mem_addr_q;
                head_inst_d = mem_rdata;
            end else begin
                tail_pc_d   = mem_addr_q;
                tail_inst_d = mem_rdata;
            end
`else
            head_pc_d   = mem_addr_q;
            head_inst_d = mem_rdata;
`endif
        end
    end

    // IF/ID register: redirect beats stall, stall beats FIFO pop, FIFO beats bypass.
    always_comb begin
        pc_d    = pc_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        if (br_taken) begin
            inst_d  = C_NOP;
            valid_d = 1'b0;
        end else if (stall) begin
            valid_d = valid_q;
        end else if (!fifo_empty) begin
            pc_d    = head_pc_q;
            inst_d  = head_inst_q;
            valid_d = 1'b1;
        end else if (bypass) begin
            pc_d    = mem_addr_q;
            inst_d  = mem_rdata;
            valid_d = 1'b1;
        end else begin
            inst_d  = C_NOP;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q        <= 32'h0;
            inst_q      <= C_NOP;
            valid_q     <= 1'b0;
            cnt_q       <= 2'd0;
            head_pc_q   <= 32'h0;
            head_inst_q <= 32'h0;
`ifdef IF_PREFETCH_EN
            tail_pc_q   <= 32'h0;
            tail_inst_q <= 32'h0;
`endif
        end else begin
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            valid_q     <= valid_d;
            cnt_q       <= cnt_d;
            head_pc_q   <= head_pc_d;
            head_inst_q <= head_inst_d;
`ifdef IF_PREFETCH_EN
            tail_pc_q   <= tail_pc_d;
            tail_inst_q <= tail_inst_d;
`endif
        end
    end

    // Fetch FSM. In WAIT, mem_addr_q always equals fetch_pc_q; a request only
    // starts when the FIFO can absorb its data even if decode stalls.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 32'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (br_taken) begin
                        fetch_pc_q <= redirect_pc;
                    end else if (cnt_q < C_DEPTH) begin
                        state_q    <= S_WAIT;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= fetch_pc_q;
                    end
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        if (br_taken) begin
                            fetch_pc_q <= redirect_pc;
                            state_q    <= S_IDLE;
                            mem_req_q  <= 1'b0;
                        end else begin
                            fetch_pc_q <= fetch_pc_q + 32'd4;
                            if (cnt_d < C_DEPTH) begin
                                mem_addr_q <= fetch_pc_q + 32'd4;
                            end else begin
                                state_q   <= S_IDLE;
                                mem_req_q <= 1'b0;
                            end
                        end
                    end else if (br_taken) begin
                        fetch_pc_q <= redirect_pc;
                        state_q    <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (br_taken) begin
                        fetch_pc_q <= redirect_pc;
                    end
                    if (mem_ack) begin
                        state_q   <= S_IDLE;
                        mem_req_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign pc         = pc_q;
    assign inst       = inst_q;
    assign inst_valid = valid_q;

endmodule
`default_nettype wire
